mem_port: RTL and testbench

MEM_PORT -- requirements
Module: mem_port

---
 rtl/mem_port.sv | 165 ++++++++++++++++
 tb/tb_mem_port.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port.sv
// Backing-store port for a cache on the C2 bus: accepts one line read or write, talks to a
// line-wide RAM, and answers with a RESPONSE no sooner than LATENCY cycles after capture.
module mem_port #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned BUS_BYTES  = 2,
  parameter int unsigned LATENCY    = 100
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       addr_in,
  input  logic [1:0]              cmd_in,
  input  logic [BUS_BYTES*8-1:0]  data_in,
  output logic [1:0]              cmd_out,
  output logic                    cmd_oe,
  output logic [BUS_BYTES*8-1:0]  data_out,
  output logic                    data_oe,
  output logic                    ram_req,
  output logic                    ram_we,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [LINE_BYTES*8-1:0] ram_wdata,
  input  logic [LINE_BYTES*8-1:0] ram_rdata,
  input  logic                    ram_ack,
  output logic [31:0]             total_reads,
  output logic [31:0]             total_writes
);

  localparam int unsigned BEATS  = LINE_BYTES / BUS_BYTES;
  localparam int unsigned BUS_W  = BUS_BYTES * 8;
  localparam int unsigned LINE_W = LINE_BYTES * 8;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [15:0]       LAT_LAST  = 16'(LATENCY - 1);

  localparam logic [1:0] CMD_NOP  = 2'd0;
  localparam logic [1:0] CMD_RESP = 2'd1;
  localparam logic [1:0] CMD_RD   = 2'd2;
  localparam logic [1:0] CMD_WR   = 2'd3;

  typedef enum logic [2:0] {StIdle, StWrCollect, StWait, StRespWr, StRespRd} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [LINE_W-1:0]   line_q;
  logic [LINE_W-1:0]   line_shift;
  logic [BEAT_W-1:0]   beat_q;
  logic [15:0]         lat_q;
  logic                is_wr_q;
  logic                ack_seen_q;
  logic [31:0]         rd_cnt_q;
  logic [31:0]         wr_cnt_q;
  logic                lat_done;
  logic                beat_last;
  logic                ack_now;

  assign lat_done   = (lat_q == LAT_LAST);
  assign beat_last  = (beat_q == LAST_BEAT);
  // An ack only counts while this block is actually requesting.
  assign ack_now    = (state_q == StWait) & ~ack_seen_q & ram_ack;
  assign line_shift = line_q >> (32'(beat_q) * BUS_W);

  assign ram_addr     = addr_q;
  assign ram_wdata    = line_q;
  assign total_reads  = rd_cnt_q;
  assign total_writes = wr_cnt_q;

  always_comb begin
    state_d  = state_q;
    cmd_out  = CMD_NOP;
    cmd_oe   = 1'b0;
    data_out = '0;
    data_oe  = 1'b0;
    ram_req  = 1'b0;
    ram_we   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_in == CMD_RD) begin
          state_d = StWait;
        end else if (cmd_in == CMD_WR) begin
          state_d = (BEATS > 1) ? StWrCollect : StWait;
        end
      end
      StWrCollect: begin
        if (beat_last) state_d = StWait;
      end
      StWait: begin
        cmd_oe  = 1'b1;
        ram_req = ~ack_seen_q;
        ram_we  = ~ack_seen_q & is_wr_q;
        if (lat_done && (ack_seen_q || ack_now)) begin
          state_d = is_wr_q ? StRespWr : StRespRd;
        end
      end
      StRespWr: begin
        cmd_out = CMD_RESP;
        cmd_oe  = 1'b1;
        state_d = StIdle;
      end
      StRespRd: begin
        cmd_out  = CMD_RESP;
        cmd_oe   = 1'b1;
        data_oe  = 1'b1;
        data_out = line_shift[BUS_W-1:0];
        if (beat_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      line_q     <= '0;
      beat_q     <= '0;
      lat_q      <= '0;
      is_wr_q    <= 1'b0;
      ack_seen_q <= 1'b0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          lat_q      <= '0;
          ack_seen_q <= 1'b0;
          beat_q     <= '0;
          if (cmd_in == CMD_RD) begin
            addr_q  <= addr_in;
            is_wr_q <= 1'b0;
          end else if (cmd_in == CMD_WR) begin
            addr_q             <= addr_in;
            is_wr_q            <= 1'b1;
            line_q[BUS_W-1:0]  <= data_in;
            beat_q             <= BEAT_W'(1);
          end
        end
        StWrCollect: begin
          for (int k = 0; k < BEATS; k++) begin
            if (beat_q == BEAT_W'(k)) line_q[k*BUS_W +: BUS_W] <= data_in;
          end
          beat_q <= beat_q + 1'b1;
        end
        StWait: begin
          beat_q <= '0;
          if (!lat_done) lat_q <= lat_q + 16'd1;
          if (ack_now) begin
            ack_seen_q <= 1'b1;
            if (!is_wr_q) line_q <= ram_rdata;
          end
        end
        StRespWr: begin
          wr_cnt_q <= wr_cnt_q + 32'd1;
        end
        StRespRd: begin
          beat_q <= beat_q + 1'b1;
          if (beat_last) rd_cnt_q <= rd_cnt_q + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port.sv
// Randomised bench for mem_port: a line RAM responder with programmable ack delay and a
// transaction-level model of expected line contents, response timing and counters.
module tb_mem_port;

  localparam int LAT = 5;
  localparam logic [1:0] CMD_NOP  = 2'd0;
  localparam logic [1:0] CMD_RESP = 2'd1;
  localparam logic [1:0] CMD_RD   = 2'd2;
  localparam logic [1:0] CMD_WR   = 2'd3;

  logic         clk = 1'b0;
  logic         reset;
  logic [9:0]   addr_in;
  logic [1:0]   cmd_in;
  logic [15:0]  data_in;
  logic [1:0]   cmd_out;
  logic         cmd_oe;
  logic [15:0]  data_out;
  logic         data_oe;
  logic         ram_req;
  logic         ram_we;
  logic [9:0]   ram_addr;
  logic [127:0] ram_wdata;
  logic [127:0] ram_rdata;
  logic         ram_ack;
  logic [31:0]  total_reads;
  logic [31:0]  total_writes;

  mem_port #(
    .ADDR_W    (10),
    .LINE_BYTES(16),
    .BUS_BYTES (2),
    .LATENCY   (LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .addr_in     (addr_in),
    .cmd_in      (cmd_in),
    .data_in     (data_in),
    .cmd_out     (cmd_out),
    .cmd_oe      (cmd_oe),
    .data_out    (data_out),
    .data_oe     (data_oe),
    .ram_req     (ram_req),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .ram_ack     (ram_ack),
    .total_reads (total_reads),
    .total_writes(total_writes)
  );

  always #5 clk = ~clk;

  logic [127:0] ram_mem   [0:1023];
  logic [127:0] model_mem [0:1023];
  int n_checks   = 0;
  int n_pass     = 0;
  int cyc        = 0;
  int ack_delay  = 2;
  int req_starts = 0;
  int n_reads    = 0;
  int n_writes   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // RAM: acks ack_delay cycles into a request, holds ack for one cycle.
  initial begin
    int  req_cnt;
    bit  prev_req;
    req_cnt   = 0;
    prev_req  = 1'b0;
    ram_ack   = 1'b0;
    ram_rdata = '0;
    forever begin
      @(negedge clk);
      if (ram_ack) begin
        ram_ack = 1'b0;
        req_cnt = 0;
      end else if (ram_req) begin
        req_cnt++;
        if (req_cnt >= ack_delay) begin
          ram_ack   = 1'b1;
          ram_rdata = ram_mem[ram_addr];
          if (ram_we) ram_mem[ram_addr] = ram_wdata;
        end
      end else begin
        req_cnt = 0;
      end
      if (ram_req && !prev_req) req_starts++;
      prev_req = ram_req;
    end
  end

  // Wait for RESPONSE; checks the RAM request on the way. Returns at the first RESPONSE negedge.
  task automatic wait_resp(input logic [9:0] a, input bit wr, input logic [127:0] line,
                           input bit noise, output bit got);
    bit seen_req;
    seen_req = 1'b0;
    got      = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (cmd_oe && cmd_out == CMD_RESP) begin
        got = 1'b1;
      end else if (ram_req && !seen_req) begin
        seen_req = 1'b1;
        check_eq("req_addr", 128'(ram_addr), 128'(a));
        check_eq("req_we", 128'(ram_we), 128'(wr));
        if (wr) check_eq("req_wdata", ram_wdata, line);
      end
      cmd_in  = (noise && !got) ? 2'($urandom_range(2, 3)) : CMD_NOP;
      addr_in = 10'($urandom);
    end
    if (!got) check_eq("resp_timeout", 128'(0), 128'(1));
  endtask

  // All transactions start driving at the current negedge and return at the first IDLE negedge.
  task automatic do_read(input logic [9:0] a, input int d, input bit noise);
    int c0, starts0;
    bit got;
    logic [127:0] exp_line;
    ack_delay = d;
    starts0   = req_starts;
    c0        = cyc;
    cmd_in    = CMD_RD;
    addr_in   = a;
    data_in   = 16'($urandom);
    exp_line  = model_mem[a];
    wait_resp(a, 1'b0, '0, noise, got);
    if (!got) return;
    check_eq("rd_resp_cycle", 128'(cyc), 128'(c0 + 1 + ((LAT > d) ? LAT : d)));
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      check_eq("rd_oe", 128'({cmd_oe, data_oe, cmd_out}), 128'({2'b11, CMD_RESP}));
      check_eq("rd_beat", 128'(data_out), 128'(exp_line[k*16 +: 16]));
    end
    @(negedge clk);
    n_reads++;
    check_eq("rd_idle_oe", 128'({cmd_oe, data_oe, ram_req}), 128'(0));
    check_eq("total_reads", 128'(total_reads), 128'(n_reads));
    check_eq("rd_req_count", 128'(req_starts - starts0), 128'(1));
  endtask

  task automatic do_write(input logic [9:0] a, input logic [127:0] line, input int d,
                          input bit noise);
    int c0, starts0;
    bit got;
    ack_delay = d;
    starts0   = req_starts;
    c0        = cyc;
    cmd_in    = CMD_WR;
    addr_in   = a;
    data_in   = line[15:0];
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      cmd_in  = noise ? 2'($urandom_range(0, 3)) : CMD_NOP;
      addr_in = 10'($urandom);
      data_in = line[k*16 +: 16];
    end
    model_mem[a] = line;
    wait_resp(a, 1'b1, line, noise, got);
    if (!got) return;
    check_eq("wr_resp_cycle", 128'(cyc), 128'(c0 + 8 + ((LAT > d) ? LAT : d)));
    check_eq("wr_data_oe", 128'(data_oe), 128'(0));
    @(negedge clk);
    n_writes++;
    check_eq("wr_one_cycle", 128'({cmd_oe, ram_req}), 128'(0));
    check_eq("total_writes", 128'(total_writes), 128'(n_writes));
    check_eq("wr_req_count", 128'(req_starts - starts0), 128'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] line;
    int resp_cnt, req_cnt;
    for (int i = 0; i < 1024; i++) begin
      line         = {$urandom, $urandom, $urandom, $urandom};
      ram_mem[i]   = line;
      model_mem[i] = line;
    end
    ram_mem[10'h155]   = 128'h0F0E0D0C0B0A09080706050403020100;
    model_mem[10'h155] = 128'h0F0E0D0C0B0A09080706050403020100;

    reset   = 1'b1;
    cmd_in  = CMD_RD;
    addr_in = '0;
    data_in = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", 128'({cmd_oe, data_oe, ram_req, ram_we, cmd_out, data_out}),
             128'(0));
    check_eq("reset_counters", 128'({total_reads, total_writes}), 128'(0));
    reset  = 1'b0;
    cmd_in = CMD_NOP;
    @(negedge clk);

    do_read(10'h155, 2, 1'b0);
    line = 128'h88887777666655554444333322221111;
    do_write(10'h02A, line, 2, 1'b0);
    check_eq("ram_written", ram_mem[10'h02A], line);
    do_read(10'h155, 20, 1'b0);
    do_read(10'h0C3, 3, 1'b1);
    do_write(10'h033, {$urandom, $urandom, $urandom, $urandom}, 1, 1'b0);
    do_read(10'h033, 1, 1'b0);

    // Reset after the fourth beat of a write: nothing may be committed.
    cmd_in  = CMD_WR;
    addr_in = 10'h0AA;
    data_in = 16'hA0A0;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      cmd_in  = CMD_NOP;
      data_in = 16'($urandom);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_collect_oe", 128'({cmd_oe, data_oe, ram_req}), 128'(0));
    check_eq("rst_collect_cnt", 128'({total_reads, total_writes}), 128'(0));
    reset    = 1'b0;
    n_reads  = 0;
    n_writes = 0;
    do_read(10'h0AA, 2, 1'b0);

    // Reset while waiting on a slow RAM: no RESPONSE and no further request.
    ack_delay = 6;
    cmd_in    = CMD_RD;
    addr_in   = 10'h011;
    @(negedge clk);
    cmd_in = CMD_NOP;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    resp_cnt = 0;
    req_cnt  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_oe) resp_cnt++;
      if (ram_req) req_cnt++;
    end
    check_eq("rst_wait_silent", 128'({resp_cnt, req_cnt}), 128'(0));
    check_eq("rst_wait_cnt", 128'(total_reads), 128'(0));
    n_reads  = 0;
    n_writes = 0;

    // Back-to-back write then read of the same line.
    line = {$urandom, $urandom, $urandom, $urandom};
    do_write(10'h0F0, line, 4, 1'b1);
    do_read(10'h0F0, 2, 1'b0);

    for (int t = 0; t < 40; t++) begin
      logic [9:0] a;
      int d;
      a = 10'($urandom_range(0, 15));
      d = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(1, 12);
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, {$urandom, $urandom, $urandom, $urandom}, d, 1'($urandom_range(0, 1)));
      end else begin
        do_read(a, d, 1'($urandom_range(0, 1)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
